// File: rtl/sensor_frame_assembler_pkg.sv
// Shared types and constants for the sensor frame assembler.
// A frame is 32 link bytes packed into eight 32-bit words.
package sensor_pkg;

  localparam int FRAME_WORDS    = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int FRAME_BYTES    = FRAME_WORDS * BYTES_PER_WORD;
  localparam int BIDX_W         = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    GAP     = 2'd2
  } sfa_state_t;

  function automatic logic is_last_byte(input logic [BIDX_W-1:0] idx);
    return idx == BIDX_W'(FRAME_BYTES - 1);
  endfunction

endpackage

// File: rtl/sensor_frame_assembler_word_packer.sv
// Staging buffer: drops each accepted byte into its word lane and tracks
// the byte index within the frame in progress.
module sensor_word_packer
  import sensor_pkg::*;
(
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic                          clear,
  input  logic                          accept,
  input  logic [7:0]                    data,
  output logic [FRAME_WORDS-1:0][31:0]  stage,
  output logic [BIDX_W-1:0]             byte_idx
);

  logic [FRAME_WORDS-1:0][31:0] stage_r;
  logic [BIDX_W-1:0]            idx_r;

  // Byte lane write and index advance; index wraps to 0 after the last byte.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      stage_r <= '0;
      idx_r   <= '0;
    end else if (clear) begin
      stage_r <= '0;
      idx_r   <= '0;
    end else if (accept) begin
      stage_r[idx_r[4:2]][{idx_r[1:0], 3'b000} +: 8] <= data;
      idx_r <= is_last_byte(idx_r) ? '0 : idx_r + BIDX_W'(1);
    end
  end

  assign stage    = stage_r;
  assign byte_idx = idx_r;

endmodule

// File: rtl/sensor_frame_assembler.sv
// Sensor link front-end: packs 32-byte runs into 8-word frames, then holds
// off the link for GAP_CYCLES cycles before taking the next byte.
module sensor_frame_assembler
  import sensor_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             sensor_en,
  input  logic             raw_valid,
  input  logic [7:0]       raw_data,
  output logic             raw_ready,
  output logic             sensor_ready,
  output logic [31:0]      sensor_out_0,
  output logic [31:0]      sensor_out_1,
  output logic [31:0]      sensor_out_2,
  output logic [31:0]      sensor_out_3,
  output logic [31:0]      sensor_out_4,
  output logic [31:0]      sensor_out_5,
  output logic [31:0]      sensor_out_6,
  output logic [31:0]      sensor_out_7,
  output logic             frame_abort,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam bit NO_GAP   = (GAP_CYCLES == 0);

  sfa_state_t                   state_r, state_s;
  logic [GAP_W-1:0]             gap_cnt_r, gap_cnt_s;
  logic                         accept_s, done_s, abort_s;
  logic [FRAME_WORDS-1:0][31:0] stage_s, frame_s, frame_r;
  logic [BIDX_W-1:0]            byte_idx_s;
  logic [CNT_W-1:0]             frame_cnt_r;
  logic                         sensor_ready_r, frame_abort_r;

  assign raw_ready = (state_r == COLLECT) & sensor_en;
  assign accept_s  = raw_valid & raw_ready;
  assign done_s    = accept_s & is_last_byte(byte_idx_s);

  sensor_word_packer u_packer (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .clear    (abort_s),
    .accept   (accept_s),
    .data     (raw_data),
    .stage    (stage_s),
    .byte_idx (byte_idx_s)
  );

  // The final byte is still on raw_data, so splice it into word 7's top lane.
  always_comb begin
    frame_s = stage_s;
    frame_s[FRAME_WORDS-1][31:24] = raw_data;
  end

  // Next-state, gap counting and abort detection.
  always_comb begin
    state_s   = state_r;
    gap_cnt_s = gap_cnt_r;
    abort_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (sensor_en) state_s = COLLECT;
        else           state_s = IDLE;
      end
      COLLECT: begin
        if (!sensor_en) begin
          state_s = IDLE;
          abort_s = (byte_idx_s != '0);
        end else if (done_s) begin
          state_s   = NO_GAP ? COLLECT : GAP;
          gap_cnt_s = '0;
        end else begin
          state_s = COLLECT;
        end
      end
      GAP: begin
        if (!sensor_en) begin
          state_s   = IDLE;
          gap_cnt_s = '0;
        end else if (gap_cnt_r == GAP_W'(GAP_LAST)) begin
          state_s   = COLLECT;
          gap_cnt_s = '0;
        end else begin
          gap_cnt_s = gap_cnt_r + GAP_W'(1);
        end
      end
      default: begin
        state_s   = IDLE;
        gap_cnt_s = '0;
      end
    endcase
  end

  // State, output frame and status registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_r        <= IDLE;
      gap_cnt_r      <= '0;
      frame_r        <= '0;
      frame_cnt_r    <= '0;
      sensor_ready_r <= 1'b0;
      frame_abort_r  <= 1'b0;
    end else begin
      state_r        <= state_s;
      gap_cnt_r      <= gap_cnt_s;
      sensor_ready_r <= done_s;
      frame_abort_r  <= abort_s;
      if (done_s) begin
        frame_r     <= frame_s;
        frame_cnt_r <= frame_cnt_r + CNT_W'(1);
      end
    end
  end

  assign sensor_ready = sensor_ready_r;
  assign frame_abort  = frame_abort_r;
  assign frame_cnt    = frame_cnt_r;
  assign sensor_out_0 = frame_r[0];
  assign sensor_out_1 = frame_r[1];
  assign sensor_out_2 = frame_r[2];
  assign sensor_out_3 = frame_r[3];
  assign sensor_out_4 = frame_r[4];
  assign sensor_out_5 = frame_r[5];
  assign sensor_out_6 = frame_r[6];
  assign sensor_out_7 = frame_r[7];

endmodule

// File: tb/tb_sensor_frame_assembler.sv
// Bench for sensor_frame_assembler: frame vectors table, scoreboarded frames,
// abort / reset / counter-wrap sequences (second instance with CNT_W=2, no gap).
module tb_sensor_frame_assembler;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        sensor_en = 1'b0;
  logic        en2 = 1'b0;
  logic        raw_valid = 1'b0;
  logic [7:0]  raw_data = 8'h00;
  logic        raw_ready, sensor_ready, frame_abort;
  logic [31:0] so [8];
  logic [15:0] frame_cnt;
  logic        raw_ready2, sensor_ready2, frame_abort2;
  logic [31:0] so2 [8];
  logic [1:0]  frame_cnt2;

  always #5 ACLK = ~ACLK;

  sensor_frame_assembler #(.GAP_CYCLES(4), .CNT_W(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .sensor_en(sensor_en), .raw_valid(raw_valid),
    .raw_data(raw_data), .raw_ready(raw_ready), .sensor_ready(sensor_ready),
    .sensor_out_0(so[0]), .sensor_out_1(so[1]), .sensor_out_2(so[2]), .sensor_out_3(so[3]),
    .sensor_out_4(so[4]), .sensor_out_5(so[5]), .sensor_out_6(so[6]), .sensor_out_7(so[7]),
    .frame_abort(frame_abort), .frame_cnt(frame_cnt)
  );

  sensor_frame_assembler #(.GAP_CYCLES(0), .CNT_W(2)) dut2 (
    .ACLK(ACLK), .ARESETn(ARESETn), .sensor_en(en2), .raw_valid(raw_valid),
    .raw_data(raw_data), .raw_ready(raw_ready2), .sensor_ready(sensor_ready2),
    .sensor_out_0(so2[0]), .sensor_out_1(so2[1]), .sensor_out_2(so2[2]), .sensor_out_3(so2[3]),
    .sensor_out_4(so2[4]), .sensor_out_5(so2[5]), .sensor_out_6(so2[6]), .sensor_out_7(so2[7]),
    .frame_abort(frame_abort2), .frame_cnt(frame_cnt2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef logic [7:0][31:0] words_t;
  typedef struct { words_t w; logic [15:0] cnt; } frm_t;
  frm_t        sb_q[$];
  int          pushed = 0;
  int          pulses = 0;
  logic [15:0] model_cnt = 16'd0;

  // Reference packing: byte i of the frame sits in word i/4, lane i%4.
  function automatic words_t pack_ref(input logic [7:0] base);
    words_t r;
    for (int i = 0; i < 32; i++) r[i/4][8*(i%4) +: 8] = base + 8'(i);
    return r;
  endfunction

  task automatic expect_frame(input logic [7:0] base);
    frm_t f;
    model_cnt = model_cnt + 16'd1;
    f.w = pack_ref(base);
    f.cnt = model_cnt;
    sb_q.push_back(f);
    pushed++;
  endtask

  // Scoreboard: every sensor_ready pulse of the main instance pops one frame.
  initial begin
    frm_t   f;
    words_t act;
    forever begin
      @(posedge ACLK); #1;
      if (sensor_ready) begin
        pulses++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got ready pulse, expected none");
        end else begin
          f = sb_q.pop_front();
          for (int i = 0; i < 8; i++) act[i] = so[i];
          if (act !== f.w || frame_cnt !== f.cnt || frame_abort !== 1'b0) begin
            errors++;
            $display("FAIL sb_frame: got out0=%h out7=%h cnt=%0d abort=%b expected out0=%h out7=%h cnt=%0d abort=0",
                     act[0], act[7], frame_cnt, frame_abort, f.w[0], f.w[7], f.cnt);
          end
        end
      end
    end
  end

  task automatic send(input bit sel, input logic [7:0] base, input int n, input bit bub,
                      output int cycles);
    int k;
    bit phase, acc, rdy;
    k = 0; phase = 1'b0; cycles = 0;
    for (int guard = 0; guard < 400 && k < n; guard++) begin
      raw_valid = !(bub && phase);
      raw_data  = base + 8'(k);
      @(negedge ACLK);
      rdy = sel ? raw_ready2 : raw_ready;
      acc = raw_valid & rdy;
      @(posedge ACLK); #1;
      if (rdy) cycles++;
      if (acc) begin k++; phase = 1'b1; end
      else phase = 1'b0;
    end
    raw_valid = 1'b0;
    if (k < n) begin
      checks++; errors++;
      $display("FAIL send_timeout: got %0d bytes expected %0d", k, n);
    end
  endtask

  // Counts raw_ready-low cycles while offering a junk byte that must not be taken.
  task automatic measure_gap(output int n);
    n = 0;
    raw_valid = 1'b1;
    raw_data  = 8'hEE;
    for (int g = 0; g < 50; g++) begin
      @(negedge ACLK);
      if (raw_ready) break;
      n++;
      @(posedge ACLK); #1;
    end
    raw_valid = 1'b0;
    @(posedge ACLK); #1;
  endtask

  typedef struct {
    logic [7:0]  base;
    bit          bub;
    logic [31:0] e0;
    logic [31:0] e7;
    int          ecyc;
  } vec_t;
  vec_t vt [4];

  initial begin
    int cyc, gap;
    vt[0] = '{8'h00, 1'b0, 32'h03020100, 32'h1F1E1D1C, 32};
    vt[1] = '{8'h20, 1'b0, 32'h23222120, 32'h3F3E3D3C, 32};
    vt[2] = '{8'h00, 1'b1, 32'h03020100, 32'h1F1E1D1C, 63};
    vt[3] = '{8'h60, 1'b0, 32'h63626160, 32'h7F7E7D7C, 32};

    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_out0", so[0], 32'h0);
    chk("rst_out7", so[7], 32'h0);
    chk("rst_cnt", 32'(frame_cnt), 32'h0);
    chk("rst_ready", 32'(sensor_ready), 32'h0);
    chk("rst_abort", 32'(frame_abort), 32'h0);
    chk("rst_raw_ready", 32'(raw_ready), 32'h0);
    ARESETn = 1'b1;

    sensor_en = 1'b1;
    chk("en_rise_ready_pre", 32'(raw_ready), 32'h0);
    @(posedge ACLK); #1;
    chk("en_rise_ready_post", 32'(raw_ready), 32'h1);

    for (int i = 0; i < 4; i++) begin
      expect_frame(vt[i].base);
      send(1'b0, vt[i].base, 32, vt[i].bub, cyc);
      chk($sformatf("v%0d_out0", i), so[0], vt[i].e0);
      chk($sformatf("v%0d_out7", i), so[7], vt[i].e7);
      chk($sformatf("v%0d_cnt", i), 32'(frame_cnt), 32'(i + 1));
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vt[i].ecyc));
      chk($sformatf("v%0d_ready_pulse", i), 32'(sensor_ready), 32'h1);
      measure_gap(gap);
      chk($sformatf("v%0d_gap", i), 32'(gap), 32'd4);
    end

    // Abort after 10 bytes: outputs keep frame 0x60, next frame restarts at byte 0.
    send(1'b0, 8'h00, 10, 1'b0, cyc);
    sensor_en = 1'b0;
    @(posedge ACLK); #1;
    chk("abort_pulse", 32'(frame_abort), 32'h1);
    chk("abort_no_ready", 32'(sensor_ready), 32'h0);
    chk("abort_out0_held", so[0], 32'h63626160);
    chk("abort_cnt_held", 32'(frame_cnt), 32'd4);
    @(posedge ACLK); #1;
    chk("abort_one_cycle", 32'(frame_abort), 32'h0);
    sensor_en = 1'b1;
    expect_frame(8'h40);
    send(1'b0, 8'h40, 32, 1'b0, cyc);
    chk("post_abort_out0", so[0], 32'h43424140);
    chk("post_abort_out7", so[7], 32'h5F5E5D5C);
    chk("post_abort_cnt", 32'(frame_cnt), 32'd5);

    // Reset after byte 20 with the link still enabled.
    send(1'b0, 8'hA0, 20, 1'b0, cyc);
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    chk("mid_rst_out0", so[0], 32'h0);
    chk("mid_rst_out7", so[7], 32'h0);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'h0);
    chk("mid_rst_raw_ready", 32'(raw_ready), 32'h0);
    chk("mid_rst_ready", 32'(sensor_ready), 32'h0);
    ARESETn = 1'b1;
    model_cnt = 16'd0;
    expect_frame(8'h80);
    send(1'b0, 8'h80, 32, 1'b0, cyc);
    chk("post_rst_out0", so[0], 32'h83828180);
    chk("post_rst_cnt", 32'(frame_cnt), 32'd1);
    sensor_en = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;

    // Two-bit counter wrap on the no-gap instance.
    en2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(1'b1, 8'(k * 32), 32, 1'b0, cyc);
      chk($sformatf("wrap_cnt%0d", k), 32'(frame_cnt2), 32'((k + 1) % 4));
      chk($sformatf("nogap_ready%0d", k), 32'(raw_ready2), 32'h1);
      if (k == 0) chk("nogap_out0", so2[0], 32'h03020100);
    end
    en2 = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;

    chk("sb_pulses", 32'(pulses), 32'(pushed));
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
